// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. buffered long-latency results.
// Optional macro WB_ARB_BYPASS_EN lets a result skip the empty FIFO when the port is idle.
module wb_arbiter #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        pipe_stall,
  output logic [31:0] pending_rd_mask
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  typedef enum logic {IDLE, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     starve_q, starve_d;
  logic [DEPTH-1:0]  live_q, live_d;
  logic [4:0]        ent_rd_q   [DEPTH];
  logic [31:0]       ent_data_q [DEPTH];
  logic              rf_we_q, rf_we_d;
  logic [4:0]        rf_waddr_q, rf_waddr_d;
  logic [31:0]       rf_wdata_q, rf_wdata_d;

  logic              empty, full, wb_req, wb_grant, deq, push, bypass;
  logic [AW-1:0]     head_idx, tail_idx;

  assign head_idx = rd_ptr_q[AW-1:0];
  assign tail_idx = wr_ptr_q[AW-1:0];
  assign empty    = (wr_ptr_q == rd_ptr_q);
  // Extra pointer bit distinguishes full from empty when indices match.
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (tail_idx == head_idx);
  assign wb_req   = wb_valid && (wb_rd != 5'd0);

  // Grant selection, WAW kill, FIFO pointer and starvation bookkeeping.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    starve_d   = starve_q;
    live_d     = live_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    wb_grant   = 1'b0;
    deq        = 1'b0;
    bypass     = 1'b0;
    push       = 1'b0;

    case (state_q)
      IDLE: begin
        if (wb_req) begin
          wb_grant = 1'b1;
        end else if (!empty) begin
          deq = 1'b1;
`ifdef WB_ARB_BYPASS_EN
        end else if (lu_valid && (lu_rd != 5'd0)) begin
          bypass = 1'b1;
`endif
        end
        if (!empty && !deq) begin
          if (starve_q == CW'(STARVE_MAX - 1)) begin
            state_d  = DRAIN;
            starve_d = '0;
          end else begin
            starve_d = starve_q + CW'(1);
          end
        end else begin
          starve_d = '0;
        end
      end
      DRAIN: begin
        deq      = !empty;
        state_d  = IDLE;
        starve_d = '0;
      end
      default: state_d = IDLE;
    endcase

    if (wb_grant) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = wb_rd;
      rf_wdata_d = wb_data;
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (ent_rd_q[i] == wb_rd) live_d[i] = 1'b0;
      end
    end

    // A dead head frees its slot without touching the register file.
    if (deq) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      live_d[head_idx] = 1'b0;
      if (live_q[head_idx]) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = ent_rd_q[head_idx];
        rf_wdata_d = ent_data_q[head_idx];
      end
    end

    if (bypass) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = lu_rd;
      rf_wdata_d = lu_data;
    end

    push = lu_valid && !full && (lu_rd != 5'd0) && !bypass;
    if (push) begin
      wr_ptr_d         = wr_ptr_q + (AW+1)'(1);
      live_d[tail_idx] = !(wb_grant && (wb_rd == lu_rd));
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      starve_q   <= '0;
      live_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      starve_q   <= starve_d;
      live_q     <= live_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Payload storage needs no reset; the live bits gate every use of it.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_rd_q[tail_idx]   <= lu_rd;
      ent_data_q[tail_idx] <= lu_data;
    end
  end

  always_comb begin
    pending_rd_mask = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (live_q[i]) pending_rd_mask = pending_rd_mask | (32'(1) << ent_rd_q[i]);
    end
    pending_rd_mask[0] = 1'b0;
  end

  assign lu_ready   = !full;
  assign pipe_stall = (state_q == DRAIN);
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;

endmodule
